// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII receive path.
package ether_pkg;

  typedef logic [1:0] dibit_t;

  typedef enum logic [2:0] {
    RESYNC   = 3'd0,
    IDLE     = 3'd1,
    PREAMBLE = 3'd2,
    DATA     = 3'd3,
    DROP     = 3'd4
  } ether_rx_state;

  localparam dibit_t PREAMBLE_DIBIT = 2'b01;
  localparam dibit_t SFD_DIBIT      = 2'b11;

  // 1528 bytes, four dibits per byte
  localparam int unsigned DEFAULT_MAX_DIBITS = 6112;

endpackage

// File: rtl/ether_rx_if.sv
// RMII receive pins plus the payload stream and frame status pulses.
interface ether_rx_if;
  import ether_pkg::*;

  logic   crsdv;
  dibit_t rxd;
  logic   axiov;
  dibit_t axiod;
  logic   frame_done;
  logic   frame_err;

  // master: PHY side driving the wire and consuming the stream
  modport master (
    output crsdv, rxd,
    input  axiov, axiod, frame_done, frame_err
  );

  modport slave (
    input  crsdv, rxd,
    output axiov, axiod, frame_done, frame_err
  );

endinterface

// File: rtl/ether_rx.sv
// RMII receive front end: strips preamble/SFD and streams payload dibits
// with a fixed one-cycle latency, flagging clean or aborted frame ends.
module ether_rx
  import ether_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 8,
  parameter int unsigned MAX_DIBITS   = DEFAULT_MAX_DIBITS
) (
  input  logic       clk,
  input  logic       rst,
  ether_rx_if.slave  rx
);

  localparam int unsigned PRE_W = $clog2(MIN_PREAMBLE + 2);
  localparam int unsigned CNT_W = $clog2(MAX_DIBITS + 1);

  localparam logic [PRE_W-1:0] PRE_SAT = PRE_W'(MIN_PREAMBLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIBITS);

  ether_rx_state state_q, state_d;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic             axiov_q, axiov_d;
  dibit_t           axiod_q, axiod_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic is_pre;
  logic is_sfd;
  logic pre_ok;
  logic pay_full;
  logic pay_clean;

  assign is_pre    = (rx.rxd == PREAMBLE_DIBIT);
  assign is_sfd    = (rx.rxd == SFD_DIBIT);
  assign pre_ok    = (pre_cnt_q >= PRE_SAT);
  assign pay_full  = (pay_cnt_q == CNT_MAX);
  // a well-formed frame carries whole bytes and at least one of them
  assign pay_clean = (pay_cnt_q != '0) && (pay_cnt_q[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESYNC: begin
        if (!rx.crsdv) state_d = IDLE;
      end
      IDLE: begin
        if (rx.crsdv) state_d = is_pre ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rx.crsdv) begin
          state_d = IDLE;
        end else if (is_pre) begin
          state_d = PREAMBLE;
        end else if (is_sfd && pre_ok) begin
          state_d = DATA;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!rx.crsdv) begin
          state_d = IDLE;
        end else if (pay_full) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (!rx.crsdv) state_d = IDLE;
      end
      default: state_d = RESYNC;
    endcase
  end

  // Output and counter next values
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    pay_cnt_d = pay_cnt_q;
    axiov_d   = 1'b0;
    axiod_d   = 2'b00;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx.crsdv && is_pre) pre_cnt_d = PRE_W'(1);
      end
      PREAMBLE: begin
        if (rx.crsdv) begin
          if (is_pre && !pre_ok) begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
          if (is_sfd && pre_ok) begin
            pay_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (rx.crsdv) begin
          if (pay_full) begin
            err_d = 1'b1;
          end else begin
            axiov_d   = 1'b1;
            axiod_d   = rx.rxd;
            pay_cnt_d = pay_cnt_q + CNT_W'(1);
          end
        end else begin
          done_d = pay_clean;
          err_d  = !pay_clean;
        end
      end
      default: begin
        pre_cnt_d = pre_cnt_q;
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      pay_cnt_q <= '0;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rx.axiov      = axiov_q;
  assign rx.axiod      = axiod_q;
  assign rx.frame_done = done_q;
  assign rx.frame_err  = err_q;

endmodule

// File: tb/tb_ether_rx.sv
// Frame-level bench for ether_rx: each frame's expected output stream is
// derived from its preamble/SFD/payload shape and compared every cycle.
module tb_ether_rx;
  import ether_pkg::*;

  localparam int MIN_PRE = 8;
  localparam int MAXD    = DEFAULT_MAX_DIBITS;

  typedef logic [1:0] dq_t[$];

  typedef struct {
    logic       r;
    logic       c;
    logic [1:0] d;
  } stim_t;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       dn;
    logic       er;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  ether_rx_if bus ();

  ether_rx #(
    .MIN_PREAMBLE (MIN_PRE),
    .MAX_DIBITS   (MAXD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus)
  );

  stim_t sq[$];
  exp_t  eq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int v_cnt, dn_cnt, er_cnt, first_v;
  logic [1:0] cap[$];

  function automatic logic [1:0] rnd2();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic void push(logic r, logic c, logic [1:0] d,
                               logic v, logic [1:0] od, logic dn, logic er);
    stim_t s;
    exp_t  e;
    s = '{r, c, d};
    e = '{v, od, dn, er};
    sq.push_back(s);
    eq.push_back(e);
  endfunction

  function automatic void quiet(logic c, logic [1:0] d);
    push(1'b0, c, d, 1'b0, 2'b00, 1'b0, 1'b0);
  endfunction

  function automatic void gap(int n);
    for (int i = 0; i < n; i++) quiet(1'b0, rnd2());
  endfunction

  // payload; dibits after index rst_at are only 01/11 (preamble lookalikes)
  function automatic dq_t rand_pl(int n, int rst_at);
    dq_t q;
    for (int i = 0; i < n; i++) begin
      if (rst_at >= 0 && i > rst_at) q.push_back($urandom_range(0, 1) != 0 ? 2'b01 : 2'b11);
      else                           q.push_back(rnd2());
    end
    return q;
  endfunction

  // frame with a valid SFD; expectations follow from payload length alone
  function automatic void frame(int pre, dq_t pl, int rst_at);
    int  n;
    logic cln;
    n = pl.size();
    for (int i = 0; i < pre; i++) quiet(1'b1, 2'b01);
    quiet(1'b1, 2'b11);
    for (int i = 0; i < n; i++) begin
      if (rst_at >= 0 && i == rst_at)     push(1'b1, 1'b1, pl[i], 1'b0, 2'b00, 1'b0, 1'b0);
      else if (rst_at >= 0 && i > rst_at) quiet(1'b1, pl[i]);
      else if (i < MAXD)                  push(1'b0, 1'b1, pl[i], 1'b1, pl[i], 1'b0, 1'b0);
      else if (i == MAXD)                 push(1'b0, 1'b1, pl[i], 1'b0, 2'b00, 1'b0, 1'b1);
      else                                quiet(1'b1, pl[i]);
    end
    cln = (n > 0) && (n % 4 == 0);
    if (rst_at >= 0 || n > MAXD) quiet(1'b0, rnd2());
    else push(1'b0, 1'b0, rnd2(), 1'b0, 2'b00, cln, !cln);
  endfunction

  // preamble shorter than required, then SFD and junk: nothing out
  function automatic void short_frame(int pre, int n);
    for (int i = 0; i < pre; i++) quiet(1'b1, 2'b01);
    quiet(1'b1, 2'b11);
    for (int i = 0; i < n; i++) quiet(1'b1, rnd2());
    quiet(1'b0, rnd2());
  endfunction

  function automatic void bad_dibit_frame(int pre, int n);
    for (int i = 0; i < pre; i++) quiet(1'b1, 2'b01);
    quiet(1'b1, $urandom_range(0, 1) != 0 ? 2'b00 : 2'b10);
    for (int i = 0; i < n; i++) quiet(1'b1, rnd2());
    quiet(1'b0, rnd2());
  endfunction

  function automatic void cut_preamble(int pre);
    for (int i = 0; i < pre; i++) quiet(1'b1, 2'b01);
    quiet(1'b0, rnd2());
  endfunction

  task automatic compare(int k);
    exp_t e;
    logic ok;
    e = eq[k];
    n_cmp++;
    ok = (bus.axiov === e.v) && (bus.frame_done === e.dn) && (bus.frame_err === e.er) &&
         (!e.v || bus.axiod === e.d);
    if (!ok) begin
      n_bad++;
      $display("FAIL cycle%0d: got v=%b d=%b done=%b err=%b, want v=%b d=%b done=%b err=%b",
               k, bus.axiov, bus.axiod, bus.frame_done, bus.frame_err, e.v, e.d, e.dn, e.er);
    end
    if (bus.axiov === 1'b1) begin
      v_cnt++;
      cap.push_back(bus.axiod);
      if (first_v < 0) first_v = k;
    end
    if (bus.frame_done === 1'b1) dn_cnt++;
    if (bus.frame_err === 1'b1)  er_cnt++;
  endtask

  task automatic run();
    v_cnt = 0; dn_cnt = 0; er_cnt = 0; first_v = -1;
    cap.delete();
    for (int k = 0; k < sq.size(); k++) begin
      rst       = sq[k].r;
      bus.crsdv = sq[k].c;
      bus.rxd   = sq[k].d;
      @(posedge clk);
      @(negedge clk);
      compare(k);
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic chk(string name, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  initial begin
    dq_t pl;
    dq_t lit;
    int  t;
    int  n;
    int  ra;

    // reset, then a quiet line so the receiver leaves resync
    push(1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    push(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    gap(2);
    run();

    // long preamble, 8 known dibits
    lit = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    frame(28, lit, -1);
    gap(2);
    run();
    chk("basic_valid_cycles", v_cnt, 8);
    chk("basic_done", dn_cnt, 1);
    chk("basic_err", er_cnt, 0);
    chk("basic_first_valid", first_v, 29);
    chk("basic_len", cap.size(), 8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk("basic_dibit", int'(cap[i]), int'(lit[i]));

    // short preamble is dropped, next good frame still received
    short_frame(4, 8);
    frame(10, rand_pl(8, -1), -1);
    gap(2);
    run();
    chk("short_valid_cycles", v_cnt, 8);
    chk("short_done", dn_cnt, 1);
    chk("short_err", er_cnt, 0);

    // non-multiple-of-4 payload
    frame(8, rand_pl(6, -1), -1);
    gap(2);
    run();
    chk("odd_valid_cycles", v_cnt, 6);
    chk("odd_done", dn_cnt, 0);
    chk("odd_err", er_cnt, 1);

    // overlength
    frame(8, rand_pl(MAXD + 5, -1), -1);
    gap(2);
    run();
    chk("long_valid_cycles", v_cnt, MAXD);
    chk("long_done", dn_cnt, 0);
    chk("long_err", er_cnt, 1);

    // reset at payload dibit 3, then a normal frame
    frame(8, rand_pl(16, 3), 3);
    frame(8, rand_pl(12, -1), -1);
    gap(2);
    run();
    chk("rst_valid_cycles", v_cnt, 15);
    chk("rst_done", dn_cnt, 1);
    chk("rst_err", er_cnt, 0);

    // back-to-back with a single idle sample between
    frame(8, rand_pl(12, -1), -1);
    frame(8, rand_pl(20, -1), -1);
    gap(2);
    run();
    chk("b2b_valid_cycles", v_cnt, 32);
    chk("b2b_done", dn_cnt, 2);
    chk("b2b_err", er_cnt, 0);

    // random mix of good, malformed and interrupted frames
    for (int f = 0; f < 150; f++) begin
      t = $urandom_range(0, 9);
      if (t <= 5) begin
        frame($urandom_range(MIN_PRE, MIN_PRE + 6), rand_pl($urandom_range(0, 40), -1), -1);
      end else if (t == 6) begin
        short_frame($urandom_range(0, MIN_PRE - 1), $urandom_range(0, 20));
      end else if (t == 7) begin
        bad_dibit_frame($urandom_range(0, 12), $urandom_range(0, 20));
      end else if (t == 8) begin
        cut_preamble($urandom_range(1, 12));
      end else begin
        n  = $urandom_range(2, 24);
        ra = $urandom_range(0, n - 1);
        pl = rand_pl(n, ra);
        frame($urandom_range(MIN_PRE, MIN_PRE + 4), pl, ra);
      end
      gap($urandom_range(0, 3));
    end
    gap(2);
    run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ether_rx.md
# ether_rx

RMII receive front end for the 50 MHz Ethernet path. Samples `crsdv`/`rxd` every clock and tracks preamble and SFD. Strips both, then streams only the frame payload dibits, from destination MAC through FCS, as a contiguous AXI-style valid/data stream. Its output feeds the dibit-reordering stage directly. It also reports a clean end of frame or an aborted/malformed frame with single-cycle pulses.

## Interface
- `MIN_PREAMBLE`, default 8: minimum number of consecutive `2'b01` dibits required before the SFD dibit `2'b11`.
- `MAX_DIBITS`, default 6112: maximum payload dibits per frame (1528 bytes × 4); exceeding it aborts the frame.
- `clk`, in, 1: 50 MHz RMII reference clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `crsdv`, in, 1: RMII carrier-sense/data-valid.
- `rxd`, in, 2: RMII receive dibit, LSB-first on the wire.
- `axiov`, out, 1: payload dibit valid; contiguous high for a whole frame.
- `axiod`, out, 2: payload dibit, passed through unmodified (wire order).
- `frame_done`, out, 1: one-cycle pulse when a frame ends cleanly.
- `frame_err`, out, 1: one-cycle pulse when a frame ends abnormally.

## Operation
- All outputs are registered. Reset values: `axiov`=0, `axiod`=2'b00, `frame_done`=0, `frame_err`=0. Internal counters reset to 0.
- After `rst`, the block enters `RESYNC`.
- States and transitions:
  - `RESYNC`: ignore input until `crsdv`=0, then go to `IDLE`. This prevents locking onto mid-frame data after reset.
  - `IDLE`: on `crsdv`=1 and `rxd`=01, go to `PREAMBLE` with the preamble count at 1. On `crsdv`=1 with any other dibit, go to `DROP`.
  - `PREAMBLE`:
    - `crsdv`=0: go to `IDLE`. No pulses.
    - `rxd`=01: increment the count, saturating at `MIN_PREAMBLE`.
    - `rxd`=11 with count ≥ `MIN_PREAMBLE`: go to `DATA`. The payload count is cleared.
    - `rxd`=11 with count < `MIN_PREAMBLE`, or `rxd` of 00/10: go to `DROP`.
  - `DATA`:
    - `crsdv`=1: emit `rxd` as a payload dibit and increment the payload count.
    - `crsdv`=0: end of frame. Pulse `frame_done` if the payload count is a nonzero multiple of 4, else pulse `frame_err`. Then go to `IDLE`.
    - Payload count would exceed `MAX_DIBITS`: pulse `frame_err`, drop `axiov`, and go to `DROP`.
  - `DROP`: no output. Go to `IDLE` when `crsdv`=0.
- No pulse is produced from `DROP`, `PREAMBLE` or `RESYNC` terminations other than the overlength case.
- `frame_done` and `frame_err` are mutually exclusive and never high together.
- The payload counter is wide enough for `MAX_DIBITS`+1 (13 bits at default) and never wraps.
- `rst` mid-frame: outputs go to reset values on the next edge with no pulse, and the remaining dibits of that frame are ignored via `RESYNC`.
- A new frame may start on the cycle after an end-of-frame: `crsdv` returns to 1 with `rxd`=01 one cycle after the `crsdv`=0 sample.

## Timing
- Latency is exactly 1 cycle: `axiod` at edge t+1 equals `rxd` sampled at edge t, for every payload dibit.
- The first payload dibit is the one sampled on the cycle after the SFD `11`. The SFD itself is never output.
- `axiov` is high from the cycle after the first payload sample until the cycle after the last `crsdv`=1 sample, with no gaps.
- `frame_done`/`frame_err` assert in the same cycle `axiov` first reads 0 after a frame, which is 1 cycle after the `crsdv`=0 sample.
- The overlength abort asserts `frame_err` on the cycle the (`MAX_DIBITS`+1)th dibit would have been output. That dibit is not output.
- There is no backpressure: the downstream stage must accept one dibit per cycle while `axiov`=1.

## Structure
- Shared package `ether_pkg` contains:
  - the state enum `ether_rx_state` (`RESYNC`, `IDLE`, `PREAMBLE`, `DATA`, `DROP`);
  - the constants `PREAMBLE_DIBIT`=2'b01 and `SFD_DIBIT`=2'b11;
  - the default `MAX_DIBITS`.
- Single module; no sub-module needed. The preamble and payload counters live inline.

## Test plan
- 28×`01`, `11`, 8 payload dibits (00,01,10,11,11,10,01,00), `crsdv`=0:
  - `axiov` high for exactly 8 cycles with the same sequence, starting 1 cycle after the first payload sample;
  - `frame_done` pulses once;
  - `frame_err` stays 0.
- 4×`01` then `11` (short preamble), 8 dibits -> `axiov` never asserts; no pulses; the next valid frame is received normally.
- Valid preamble/SFD, then 6 payload dibits -> 6 dibits out, then `frame_err` pulse, no `frame_done`.
- Valid frame of `MAX_DIBITS`+5 dibits:
  - exactly `MAX_DIBITS` dibits out;
  - `frame_err` pulses on the next cycle;
  - nothing further is output until `crsdv` falls.
- `rst` asserted for 1 cycle at payload dibit 3 of a 16-dibit frame, whose remaining dibits are all `01`/`11`:
  - outputs go to 0 next edge;
  - no output or pulse until `crsdv` falls;
  - a following frame is received correctly.
- Two back-to-back frames with `crsdv`=0 for 1 cycle between them -> two `frame_done` pulses; the second frame's payload is intact.
